// File: rtl/instr_issue_queue_if.sv
// Handshake bundle between instruction source, issue queue and Tomasulo dispatch.
// master = source/dispatch side, slave = the queue itself.
interface instr_issue_queue_if #(
   parameter int DEPTH = 8,
   parameter int IW    = 32
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic          flush;
   logic          in_valid;
   logic [IW-1:0] in_instr;
   logic          in_ready;
   logic          out_valid;
   logic          out_ready;
   logic [IW-1:0] out_instr;
   logic [6:0]    out_opcode;
   logic [4:0]    out_rd;
   logic [2:0]    out_funct3;
   logic [4:0]    out_rs1;
   logic [4:0]    out_rs2;
   logic [6:0]    out_funct7;
   logic [CW-1:0] count;
   logic          full;
   logic          empty;

   modport master (
      output flush, in_valid, in_instr, out_ready,
      input  in_ready, out_valid, out_instr, out_opcode, out_rd, out_funct3,
             out_rs1, out_rs2, out_funct7, count, full, empty
   );

   modport slave (
      input  flush, in_valid, in_instr, out_ready,
      output in_ready, out_valid, out_instr, out_opcode, out_rd, out_funct3,
             out_rs1, out_rs2, out_funct7, count, full, empty
   );
endinterface

// File: rtl/instr_issue_queue.sv
// In-order RV32 instruction queue feeding Tomasulo dispatch; drops all-zero bubbles
// and presents the head word with pre-split decode fields (first-word-fall-through).
module instr_issue_queue #(
   parameter int DEPTH = 8,
   parameter int IW    = 32
) (
   input logic              clk,
   input logic              reset,
   instr_issue_queue_if.slave q
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [IW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] cnt;

   logic          is_full;
   logic          is_empty;
   logic          rdy;
   logic          push;
   logic          pop;
   logic [IW-1:0] head;

   // Flags are gated by reset so outputs show reset values combinationally
   // while reset is held, before the synchronous clear has taken effect.
   always_comb begin
      is_full  = reset & (cnt == CW'(DEPTH));
      is_empty = ~reset | (cnt == '0);
      rdy      = reset & ~is_full;
      push     = q.in_valid & rdy & (q.in_instr != '0);
      pop      = ~is_empty & q.out_ready;
      head     = '0;
      if (!is_empty)
         head = mem[rd_ptr];
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else if (q.flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // Storage is not reset and not cleared by flush; only pointers define validity.
   always_ff @(posedge clk) begin
      if (reset && !q.flush && push)
         mem[wr_ptr] <= q.in_instr;
   end

   always_comb begin
      q.in_ready   = rdy;
      q.out_valid  = ~is_empty;
      q.out_instr  = head;
      q.out_opcode = head[6:0];
      q.out_rd     = head[11:7];
      q.out_funct3 = head[14:12];
      q.out_rs1    = head[19:15];
      q.out_rs2    = head[24:20];
      q.out_funct7 = head[31:25];
      q.count      = reset ? cnt : '0;
      q.full       = is_full;
      q.empty      = is_empty;
   end
endmodule

// File: tb/tb_instr_issue_queue.sv
// Directed self-checking bench for instr_issue_queue (DEPTH=8, IW=32).
module tb_instr_issue_queue;
   logic clk;
   logic reset;
   int   errors;
   int   checks;

   instr_issue_queue_if #(.DEPTH(8), .IW(32)) qif ();

   instr_issue_queue #(.DEPTH(8), .IW(32)) dut (
      .clk   (clk),
      .reset (reset),
      .q     (qif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] w [8];
   logic [31:0] held;

   initial begin
      errors = 0;
      checks = 0;
      reset  = 1'b0;
      qif.flush     = 1'b0;
      qif.in_valid  = 1'b1;
      qif.in_instr  = 32'h1234_5678;
      qif.out_ready = 1'b0;

      // 1. reset held 2 cycles with a push attempt, then released idle
      cyc();
      cyc();
      check("rst_in_ready", qif.in_ready, 0);
      check("rst_out_valid", qif.out_valid, 0);
      check("rst_empty", qif.empty, 1);
      check("rst_full", qif.full, 0);
      check("rst_count", qif.count, 0);
      check("rst_out_instr", qif.out_instr, 0);
      qif.in_valid = 1'b0;
      reset = 1'b1;
      cyc();
      check("idle_empty", qif.empty, 1);
      check("idle_count", qif.count, 0);
      check("idle_out_valid", qif.out_valid, 0);
      check("idle_out_instr", qif.out_instr, 0);
      check("idle_opcode", qif.out_opcode, 0);
      check("idle_in_ready", qif.in_ready, 1);

      // 2. add x3,x1,x2 with dispatch stalled
      qif.in_valid = 1'b1;
      qif.in_instr = 32'h0020_81B3;
      cyc();
      qif.in_valid = 1'b0;
      check("add_valid", qif.out_valid, 1);
      check("add_opcode", qif.out_opcode, 7'h33);
      check("add_rd", qif.out_rd, 3);
      check("add_rs1", qif.out_rs1, 1);
      check("add_rs2", qif.out_rs2, 2);
      check("add_funct3", qif.out_funct3, 0);
      check("add_funct7", qif.out_funct7, 0);
      check("add_count", qif.count, 1);
      for (int i = 0; i < 3; i++) begin
         cyc();
         check("stall_instr", qif.out_instr, 32'h0020_81B3);
         check("stall_valid", qif.out_valid, 1);
      end
      qif.out_ready = 1'b1;
      cyc();
      qif.out_ready = 1'b0;
      check("add_popped_empty", qif.empty, 1);

      // 3. fill to full, refuse 9th, pop-while-full refuses push, drain in order
      for (int i = 0; i < 8; i++) w[i] = 32'hA000_0000 + 32'(i * 16 + 3);
      for (int i = 0; i < 8; i++) begin
         qif.in_valid = 1'b1;
         qif.in_instr = w[i];
         cyc();
      end
      check("fill_full", qif.full, 1);
      check("fill_in_ready", qif.in_ready, 0);
      check("fill_count", qif.count, 8);
      qif.in_instr = 32'hDEAD_BEEF;
      cyc();
      check("ninth_refused_count", qif.count, 8);
      check("ninth_head", qif.out_instr, w[0]);
      for (int i = 0; i < 8; i++) begin
         check("drain_order", qif.out_instr, w[i]);
         qif.out_ready = 1'b1;
         qif.in_valid  = (i == 0);
         cyc();
         if (i == 0) begin
            check("full_pop_count", qif.count, 7);
            check("full_pop_in_ready", qif.in_ready, 1);
         end
      end
      qif.out_ready = 1'b0;
      qif.in_valid  = 1'b0;
      check("drain_empty", qif.empty, 1);
      check("drain_count", qif.count, 0);

      // 4. bubbles interleaved
      qif.in_valid = 1'b1;
      qif.in_instr = 32'h0000_0A13; cyc();
      qif.in_instr = 32'h0;         cyc();
      check("bubble_in_ready", qif.in_ready, 1);
      qif.in_instr = 32'h0000_0B13; cyc();
      qif.in_instr = 32'h0;         cyc();
      qif.in_instr = 32'h0000_0C13; cyc();
      qif.in_valid = 1'b0;
      check("bubble_count", qif.count, 3);
      qif.out_ready = 1'b1;
      check("bubble_pop_a", qif.out_instr, 32'h0000_0A13); cyc();
      check("bubble_pop_b", qif.out_instr, 32'h0000_0B13); cyc();
      check("bubble_pop_c", qif.out_instr, 32'h0000_0C13); cyc();
      qif.out_ready = 1'b0;
      check("bubble_empty", qif.empty, 1);

      // 5. preload 3, then 20 cycles of push+pop with pointer wrap
      qif.in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         qif.in_instr = 32'h0000_0100 + 32'(k);
         cyc();
      end
      qif.out_ready = 1'b1;
      for (int k = 0; k < 20; k++) begin
         check("stream_head", qif.out_instr, 32'h0000_0100 + 32'(k));
         qif.in_instr = 32'h0000_0103 + 32'(k);
         cyc();
         check("stream_count", qif.count, 3);
      end
      qif.in_valid = 1'b0;
      for (int k = 20; k < 23; k++) begin
         check("stream_tail", qif.out_instr, 32'h0000_0100 + 32'(k));
         cyc();
      end
      check("stream_empty", qif.empty, 1);

      // no same-cycle bypass on an empty queue
      qif.in_valid = 1'b1;
      qif.in_instr = 32'h0000_0293;
      check("nobypass_pre_valid", qif.out_valid, 0);
      cyc();
      qif.in_valid = 1'b0;
      check("nobypass_count", qif.count, 1);
      check("nobypass_head", qif.out_instr, 32'h0000_0293);
      cyc();
      qif.out_ready = 1'b0;
      check("nobypass_empty", qif.empty, 1);

      // 6. flush at count 5 with a concurrent push and pop
      qif.in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         qif.in_instr = 32'h0000_0500 + 32'(k);
         cyc();
      end
      check("preflush_count", qif.count, 5);
      qif.flush     = 1'b1;
      qif.out_ready = 1'b1;
      qif.in_instr  = 32'h0000_0777;
      check("flush_in_ready", qif.in_ready, 1);
      cyc();
      qif.flush     = 1'b0;
      qif.in_valid  = 1'b0;
      qif.out_ready = 1'b0;
      check("flush_count", qif.count, 0);
      check("flush_empty", qif.empty, 1);
      check("flush_out_instr", qif.out_instr, 0);
      cyc();
      check("flush_word_absent", qif.out_valid, 0);

      // post-flush pointers restart at 0 and work normally
      qif.in_valid = 1'b1;
      qif.in_instr = 32'h0000_0601; cyc();
      qif.in_instr = 32'h0000_0602; cyc();
      held = qif.out_instr;
      check("postflush_head", held, 32'h0000_0601);
      check("postflush_count", qif.count, 2);

      // reset mid-stream
      reset = 1'b0;
      qif.in_instr = 32'h0000_0603;
      cyc();
      check("midrst_count", qif.count, 0);
      check("midrst_empty", qif.empty, 1);
      check("midrst_valid", qif.out_valid, 0);
      check("midrst_in_ready", qif.in_ready, 0);
      check("midrst_out_instr", qif.out_instr, 0);
      qif.in_valid = 1'b0;
      reset = 1'b1;
      cyc();
      check("after_rst_empty", qif.empty, 1);
      check("after_rst_in_ready", qif.in_ready, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
